// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter family: width limits and
// binary/Gray conversions sized for the widest supported counter.
package gray_pkg;

    localparam int GRAY_W_MIN = 2;
    localparam int GRAY_W_MAX = 16;

    function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bit i is the XOR of g[MSB:i]; zero-extended narrower inputs decode correctly.
    function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
        logic [GRAY_W_MAX-1:0] b;
        b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
        for (int i = GRAY_W_MAX-2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic hamming1(input logic [GRAY_W_MAX-1:0] a,
                                      input logic [GRAY_W_MAX-1:0] b);
        logic [GRAY_W_MAX-1:0] d;
        int n;
        d = a ^ b;
        n = 0;
        for (int i = 0; i < GRAY_W_MAX; i++)
            if (d[i]) n++;
        return n == 1;
    endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of the
// Gray bits from the MSB down to that position.
module gray2bin_dec #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down Gray counter with binary shadow, clear, Gray load and wrap/saturate.
// Optional step checker on err is built only when GRAY_CNT_CHK_EN is defined.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int W       = 4,    // GRAY_W_MIN..GRAY_W_MAX
    parameter int WRAP    = 1,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         en,
    input  logic         up,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_gray,
    output logic [W-1:0] gray_out,
    output logic [W-1:0] bin_out,
    output logic         tc,
    output logic         wrap,
    output logic         err
);

    localparam logic [W-1:0] RST_B = W'(RST_VAL);
    localparam logic [W-1:0] RST_G = RST_B ^ (RST_B >> 1);
    localparam logic [W-1:0] MAX_B = '1;

    logic [W-1:0] bin_q, gray_q, bin_nxt, load_bin;
    logic         wrap_q, wrap_nxt;

    gray2bin_dec #(.W(W)) u_dec (
        .gray (load_gray),
        .bin  (load_bin)
    );

    assign tc = up ? (bin_q == MAX_B) : (bin_q == '0);

    always_comb begin
        bin_nxt  = bin_q;
        wrap_nxt = 1'b0;
        if (clr) begin
            bin_nxt = RST_B;
        end else if (load) begin
            bin_nxt = load_bin;
        end else if (en) begin
            if (tc) begin
                // Saturating build leaves bin_nxt at the terminal value.
                if (WRAP != 0) begin
                    bin_nxt  = up ? '0 : MAX_B;
                    wrap_nxt = 1'b1;
                end
            end else begin
                bin_nxt = up ? bin_q + 1'b1 : bin_q - 1'b1;
            end
        end
    end

    // Both registers load from the same next value so the Gray copy never lags.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            bin_q  <= RST_B;
            gray_q <= RST_G;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_nxt;
            gray_q <= W'(bin2gray(16'(bin_nxt)));
            wrap_q <= wrap_nxt;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

`ifdef GRAY_CNT_CHK_EN
    logic [W-1:0] gray_prev;
    logic         step_d, err_q;

    // A count step registered last edge must move gray_q by one bit; a
    // saturated hold leaves it unchanged and is accepted.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            gray_prev <= RST_G;
            step_d    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            gray_prev <= gray_q;
            step_d    <= en && !clr && !load;
            if (clr)
                err_q <= 1'b0;
            else if (step_d && (gray_prev != gray_q) &&
                     !hamming1(16'(gray_prev), 16'(gray_q)))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Randomised and directed bench for gray_updown_counter: a wrapping instance
// (RST_VAL=0) and a saturating instance (RST_VAL=5) against an arithmetic model.
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       rst_, en, up, clr, load;
    logic [3:0] load_gray;

    logic [3:0] gray_a, bin_a, gray_s, bin_s;
    logic       tc_a, wrap_a, err_a, tc_s, wrap_s, err_s;

    int n_chk = 0;
    int n_err = 0;
    int m_bin [2];
    bit m_wrap[2];
    bit skip_a = 1'b0;

    always #5 clk = ~clk;

    gray_updown_counter #(.W(4), .WRAP(1), .RST_VAL(0)) dut (
        .clk(clk), .rst_(rst_), .en(en), .up(up), .clr(clr), .load(load),
        .load_gray(load_gray), .gray_out(gray_a), .bin_out(bin_a),
        .tc(tc_a), .wrap(wrap_a), .err(err_a)
    );

    gray_updown_counter #(.W(4), .WRAP(0), .RST_VAL(5)) dut_sat (
        .clk(clk), .rst_(rst_), .en(en), .up(up), .clr(clr), .load(load),
        .load_gray(load_gray), .gray_out(gray_s), .bin_out(bin_s),
        .tc(tc_s), .wrap(wrap_s), .err(err_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rst_val(input int i);
        return (i == 0) ? 0 : 5;
    endfunction

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by search: the unique n in 0..15 whose Gray code is g.
    function automatic int from_gray(input int g);
        for (int n = 0; n < 16; n++)
            if (to_gray(n) == g) return n;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_bin[i]  = rst_val(i);
            m_wrap[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_wrap[i] = 1'b0;
            if (clr) m_bin[i] = rst_val(i);
            else if (load) m_bin[i] = from_gray(int'(load_gray));
            else if (en) begin
                if ((up && m_bin[i] == 15) || (!up && m_bin[i] == 0)) begin
                    if (i == 0) begin
                        m_bin[i]  = (m_bin[i] + (up ? 1 : 15)) % 16;
                        m_wrap[i] = 1'b1;
                    end
                end else begin
                    m_bin[i] = (m_bin[i] + (up ? 1 : 15)) % 16;
                end
            end
        end
    endtask

    task automatic check_all();
        if (!skip_a) begin
            chk("a_gray", 32'(gray_a), 32'(to_gray(m_bin[0])));
            chk("a_bin",  32'(bin_a),  32'(m_bin[0]));
            chk("a_tc",   32'(tc_a),   32'(up ? (m_bin[0] == 15) : (m_bin[0] == 0)));
            chk("a_wrap", 32'(wrap_a), 32'(m_wrap[0]));
            chk("a_err",  32'(err_a),  32'd0);
        end
        chk("s_gray", 32'(gray_s), 32'(to_gray(m_bin[1])));
        chk("s_bin",  32'(bin_s),  32'(m_bin[1]));
        chk("s_tc",   32'(tc_s),   32'(up ? (m_bin[1] == 15) : (m_bin[1] == 0)));
        chk("s_wrap", 32'(wrap_s), 32'(m_wrap[1]));
        chk("s_err",  32'(err_s),  32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        rst_ = 1'b0; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_gray = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_s_gray", 32'(gray_s), 32'h7);
        @(negedge clk);
        rst_ = 1'b1;

        // Count up through a full wrap.
        en = 1'b1; up = 1'b1;
        repeat (20) tick();

        // Load 0, then count down across the 0 -> MAX boundary.
        en = 1'b0; load = 1'b1; load_gray = 4'h0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        repeat (4) tick();

        // clr beats load beats en; then load alone.
        clr = 1'b1; load = 1'b1; load_gray = 4'h6; en = 1'b1; up = 1'b1;
        tick();
        clr = 1'b0; en = 1'b0;
        tick();
        chk("load_bin4", 32'(bin_a), 32'd4);
        load = 1'b0;

        // Saturation: park both at bin 15 and keep stepping up.
        load = 1'b1; load_gray = 4'h8;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        repeat (3) tick();
        chk("sat_hold", 32'(gray_s), 32'h8);

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            en        = ($urandom_range(0, 3) != 0);
            up        = ($urandom_range(0, 1) != 0);
            clr       = ($urandom_range(0, 19) == 0);
            load      = ($urandom_range(0, 9) == 0);
            load_gray = 4'($urandom_range(0, 15));
            tick();
        end
        clr = 1'b0; load = 1'b0;

        // Asynchronous reset between edges at bin 9.
        en = 1'b0; load = 1'b1; load_gray = 4'hD;
        tick();
        load = 1'b0;
        #3;
        rst_ = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_ = 1'b1;
        tick();

`ifdef GRAY_CNT_CHK_EN
        // Corrupt the binary shadow so the next step moves gray by 3 bits.
        load = 1'b1; load_gray = 4'h2;
        tick();
        load = 1'b0;
        @(negedge clk);
        skip_a = 1'b1;
        dut.bin_q = dut.bin_q ^ 4'b0100;
        en = 1'b1; up = 1'b1;
        tick();
        tick();
        chk("err_set", 32'(err_a), 32'd1);
        repeat (2) tick();
        chk("err_sticky", 32'(err_a), 32'd1);
        en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        skip_a = 1'b0;
        tick();
        chk("err_clr", 32'(err_a), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
